// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
// Merges the instruction-fetch SRAM-like port and the data SRAM-like port onto
// one shared SRAM-like bus toward the AXI bridge. The shared bus answers in
// order, so each accepted request leaves a 1-bit owner tag in an in-order FIFO.
// The head tag steers every bus_data_ok/bus_rdata back to its owner.
//
// Ports
//   clk, resetn                 core clock, asynchronous active-low reset
//   inst_sram_*  (req side)     fetch request fields in, addr_ok/data_ok/rdata out
//   data_sram_*  (req side)     load/store request fields in, addr_ok/data_ok/rdata out
//   bus_req/wr/size/wstrb/addr/wdata   muxed request toward the bridge
//   bus_addr_ok, bus_data_ok, bus_rdata shared handshake/response from the bridge
//
// Parameter
//   OUTST_DEPTH  maximum accepted-but-unanswered requests (power of 2, >= 2)
// -----------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int OUTST_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction fetch port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // data port
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    // shared bus
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HOLD_INST = 2'd1,
        S_HOLD_DATA = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               w_sel_inst;
    logic               w_sel_data;
    logic               w_sel_req;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_head_tag;

    logic [OUTST_DEPTH-1:0] r_tags;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    // Requester selection: data wins in IDLE, a HOLD state pins the owner.
    always_comb begin
        w_sel_inst = 1'b0;
        w_sel_data = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_sram_req) begin
                    w_sel_data = 1'b1;
                end else if (inst_sram_req) begin
                    w_sel_inst = 1'b1;
                end else begin
                    w_sel_inst = 1'b0;
                    w_sel_data = 1'b0;
                end
            end
            S_HOLD_INST: w_sel_inst = 1'b1;
            S_HOLD_DATA: w_sel_data = 1'b1;
            default: begin
                w_sel_inst = 1'b0;
                w_sel_data = 1'b0;
            end
        endcase
    end

    // Full is taken from the registered count only, so a pop never frees a
    // slot in the same cycle and bus_data_ok never reaches any addr_ok.
    assign w_full    = (r_count == CNT_W'(OUTST_DEPTH));
    assign w_empty   = (r_count == {CNT_W{1'b0}});
    assign w_sel_req = (w_sel_inst & inst_sram_req) | (w_sel_data & data_sram_req);

    assign bus_req   = w_sel_req & ~w_full;
    assign w_push    = bus_req & bus_addr_ok;
    assign w_pop     = bus_data_ok & ~w_empty;
    assign w_head_tag = r_tags[r_rd_ptr];

    assign inst_sram_addr_ok = w_push & w_sel_inst;
    assign data_sram_addr_ok = w_push & w_sel_data;

    assign inst_sram_data_ok = w_pop & ~w_head_tag;
    assign data_sram_data_ok = w_pop & w_head_tag;
    assign inst_sram_rdata   = bus_rdata;
    assign data_sram_rdata   = bus_rdata;

    // Request field mux; with nothing selected the inst fields pass through.
    always_comb begin
        bus_wr    = inst_sram_wr;
        bus_size  = inst_sram_size;
        bus_wstrb = inst_sram_wstrb;
        bus_addr  = inst_sram_addr;
        bus_wdata = inst_sram_wdata;
        if (w_sel_data) begin
            bus_wr    = data_sram_wr;
            bus_size  = data_sram_size;
            bus_wstrb = data_sram_wstrb;
            bus_addr  = data_sram_addr;
            bus_wdata = data_sram_wdata;
        end else begin
            bus_wr    = inst_sram_wr;
            bus_size  = inst_sram_size;
            bus_wstrb = inst_sram_wstrb;
            bus_addr  = inst_sram_addr;
            bus_wdata = inst_sram_wdata;
        end
    end

    // Grant FSM next state: lock the owner while an offered address waits.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus_req & ~bus_addr_ok) begin
                    w_state_nxt = w_sel_data ? S_HOLD_DATA : S_HOLD_INST;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD_INST, S_HOLD_DATA: begin
                if (w_push) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner-tag FIFO: tag 1 = data, 0 = inst; pointers wrap modulo depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tags   <= {OUTST_DEPTH{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_sel_data;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_arbiter
// Directed scenarios followed by randomized traffic. Every cycle all DUT
// outputs are compared with a behavioural model holding a queue of owners of
// outstanding requests and the currently locked requester (if any).
// -----------------------------------------------------------------------------
module tb_sram_bus_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    sram_bus_arbiter #(.OUTST_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: owners of outstanding requests (1 = data), lock owner
    bit m_q[$];
    int m_owner = 0;      // 0 none, 1 inst locked, 2 data locked
    int m_sel;            // requester the arbiter should be looking at now
    bit e_req, e_push, e_pop, e_head;
    bit hold_i = 1'b0, hold_d = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chkv(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Compare all outputs against the model for the inputs now applied.
    task automatic eval();
        logic [70:0] e_fields;
        #1;
        if (m_owner != 0)          m_sel = m_owner;
        else if (data_sram_req)    m_sel = 2;
        else if (inst_sram_req)    m_sel = 1;
        else                       m_sel = 0;
        e_req  = ((m_sel == 1 && inst_sram_req) || (m_sel == 2 && data_sram_req))
                 && (m_q.size() < DEPTH);
        e_push = e_req && bus_addr_ok;
        e_pop  = bus_data_ok && (m_q.size() > 0);
        e_head = (m_q.size() > 0) ? m_q[0] : 1'b0;
        if (m_sel == 2)
            e_fields = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};
        else
            e_fields = {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
        chk1 ("bus_req", bus_req, e_req);
        chkv ("bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, e_fields);
        chk1 ("inst_addr_ok", inst_sram_addr_ok, e_push && m_sel == 1);
        chk1 ("data_addr_ok", data_sram_addr_ok, e_push && m_sel == 2);
        chk1 ("inst_data_ok", inst_sram_data_ok, e_pop && !e_head);
        chk1 ("data_data_ok", data_sram_data_ok, e_pop && e_head);
        chk32("inst_rdata", inst_sram_rdata, bus_rdata);
        chk32("data_rdata", data_sram_rdata, bus_rdata);
    endtask

    // Apply the clock edge to the model and move to the next drive point.
    task automatic adv();
        if (e_pop) void'(m_q.pop_front());
        if (e_push) m_q.push_back(m_sel == 2);
        if (e_push) m_owner = 0;
        else if (e_req && !bus_addr_ok) m_owner = m_sel;
        hold_i = inst_sram_req && !(e_push && m_sel == 1);
        hold_d = data_sram_req && !(e_push && m_sel == 2);
        @(negedge clk);
    endtask

    task automatic all_low();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
        inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
        data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    endtask

    task automatic drain();
        inst_sram_req = 1'b0; data_sram_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            bus_rdata = $urandom;
            eval(); adv();
        end
        bus_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        resetn = 1'b0;
        all_low();
        @(negedge clk);
        eval(); chk1("reset_bus_req", bus_req, 1'b0); adv();
        resetn = 1'b1;

        // both request together: data first, inst next
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000;
        data_sram_req = 1'b1; data_sram_addr = 32'h0000_1000; bus_addr_ok = 1'b1;
        eval(); chk1("t1_data_granted", data_sram_addr_ok, 1'b1);
        chk1("t1_inst_waits", inst_sram_addr_ok, 1'b0); adv();
        data_sram_req = 1'b0;
        eval(); chk1("t1_inst_granted", inst_sram_addr_ok, 1'b1);
        chk32("t1_inst_addr", bus_addr, 32'h1C00_0000); adv();
        inst_sram_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
        eval(); chk1("t1_resp_to_data", data_sram_data_ok, 1'b1); adv();
        bus_rdata = 32'h2222_2222;
        eval(); chk1("t1_resp_to_inst", inst_sram_data_ok, 1'b1); adv();
        bus_data_ok = 1'b0;

        // inst address phase stalled, data arrives: bus stays on inst
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040; bus_addr_ok = 1'b0;
        eval(); adv();
        data_sram_req = 1'b1; data_sram_addr = 32'h0000_2000;
        eval(); chk32("t2_hold_inst_a", bus_addr, 32'h1C00_0040); adv();
        eval(); chk32("t2_hold_inst_b", bus_addr, 32'h1C00_0040); adv();
        bus_addr_ok = 1'b1;
        eval(); chk1("t2_inst_accept", inst_sram_addr_ok, 1'b1); adv();
        inst_sram_req = 1'b0;
        eval(); chk1("t2_data_accept", data_sram_addr_ok, 1'b1); adv();
        drain();

        // fill to DEPTH with tags 0,1,0,1
        bus_addr_ok = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            inst_sram_req = (k % 2 == 0); data_sram_req = (k % 2 == 1);
            inst_sram_addr = 32'h1C00_0100 + k; data_sram_addr = 32'h0000_3000 + k;
            eval(); adv();
        end
        inst_sram_req = 1'b1; data_sram_req = 1'b0;
        eval(); chk1("t3_full_blocks", bus_req, 1'b0); adv();
        bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        eval(); chk1("t3_inst_resp", inst_sram_data_ok, 1'b1);
        chk32("t3_inst_rdata", inst_sram_rdata, 32'hDEAD_BEEF);
        chk1("t3_no_bypass", bus_req, 1'b0); adv();
        bus_data_ok = 1'b0;
        eval(); chk1("t3_reassert", bus_req, 1'b1); adv();
        drain();

        // steady state at three outstanding with push and pop together
        bus_addr_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_sram_req = (k % 2 == 1); data_sram_req = (k % 2 == 0);
            eval(); adv();
        end
        bus_data_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            inst_sram_req = (k % 3 != 0); data_sram_req = (k % 3 == 0);
            bus_rdata = $urandom;
            eval(); chk1("t4_not_full", bus_req, 1'b1); adv();
        end
        drain();

        // response with nothing outstanding is ignored
        bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
        eval(); chk1("t5_no_inst_ok", inst_sram_data_ok, 1'b0);
        chk1("t5_no_data_ok", data_sram_data_ok, 1'b0); adv();
        bus_data_ok = 1'b0;

        // async reset mid HOLD_DATA with two outstanding
        bus_addr_ok = 1'b1;
        inst_sram_req = 1'b1; eval(); adv();
        inst_sram_req = 1'b0; data_sram_req = 1'b1; eval(); adv();
        data_sram_addr = 32'h0000_4000; bus_addr_ok = 1'b0;
        eval(); adv();
        eval();
        #1 resetn = 1'b0;
        all_low();
        #1;
        chk1("t6_rst_bus_req", bus_req, 1'b0);
        chkv("t6_rst_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, 71'd0);
        chk1("t6_rst_inst_aok", inst_sram_addr_ok, 1'b0);
        chk1("t6_rst_data_aok", data_sram_addr_ok, 1'b0);
        chk1("t6_rst_inst_dok", inst_sram_data_ok, 1'b0);
        chk1("t6_rst_data_dok", data_sram_data_ok, 1'b0);
        chk32("t6_rst_rdata", inst_sram_rdata, 32'd0);
        m_q.delete(); m_owner = 0; hold_i = 1'b0; hold_d = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bus_data_ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus_rdata = $urandom;
            eval(); chk1("t6_stale_dropped", inst_sram_data_ok | data_sram_data_ok, 1'b0); adv();
        end
        bus_data_ok = 1'b0;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0200; bus_addr_ok = 1'b1;
        eval(); chk1("t6_idle_after_rst", inst_sram_addr_ok, 1'b1); adv();
        inst_sram_req = 1'b0; bus_addr_ok = 1'b0;
        drain();

        // randomized traffic; requesters hold req and fields until accepted
        hold_i = 1'b0; hold_d = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold_i) begin
                r = $urandom;
                inst_sram_req = r[0]; inst_sram_wr = 1'b0; inst_sram_size = r[2:1];
                inst_sram_wstrb = r[6:3]; inst_sram_addr = $urandom; inst_sram_wdata = $urandom;
            end
            if (!hold_d) begin
                r = $urandom;
                data_sram_req = r[0]; data_sram_wr = r[1]; data_sram_size = r[3:2];
                data_sram_wstrb = r[7:4]; data_sram_addr = $urandom; data_sram_wdata = $urandom;
            end
            r = $urandom;
            bus_addr_ok = (r[1:0] != 2'b00);
            bus_data_ok = r[2];
            bus_rdata = $urandom;
            eval(); adv();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
